// File: rtl/div_unit_if.sv
// Divider request/response bundle between the E-stage datapath and div_unit.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, signed_div, a, b, cancel,
    input  busy, valid, hi, lo
  );

  modport slave (
    input  start, signed_div, a, b, cancel,
    output busy, valid, hi, lo
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces the remainder on hi and the quotient on lo, WIDTH iterations per divide.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [CW-1:0]    r_count, w_count_d;
  logic [WIDTH-1:0] r_rem, w_rem_d;
  logic [WIDTH-1:0] r_quo, w_quo_d;
  logic [WIDTH-1:0] r_mag_b, w_mag_b_d;
  logic [WIDTH-1:0] r_raw_a, w_raw_a_d;
  logic [WIDTH-1:0] r_hi, w_hi_d;
  logic [WIDTH-1:0] r_lo, w_lo_d;
  logic             r_sa, w_sa_d;
  logic             r_sb, w_sb_d;
  logic             r_zero, w_zero_d;
  logic             r_busy, w_busy_d;
  logic             r_valid, w_valid_d;

  logic             w_sa_in;
  logic             w_sb_in;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic             w_unused;

  assign w_sa_in = bus.a[WIDTH-1] & bus.signed_div;
  assign w_sb_in = bus.b[WIDTH-1] & bus.signed_div;

  // Remainder stays below |b|, so the shifted value fits WIDTH+1 bits; the extra MSB is the borrow.
  assign w_shift  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial  = {1'b0, w_shift} - {2'b00, r_mag_b};
  assign w_borrow = w_trial[WIDTH+1];
  assign w_rem_nx = w_borrow ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_nx = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_unused = w_trial[WIDTH];

  always_comb begin
    w_state_d = r_state;
    w_count_d = r_count;
    w_rem_d   = r_rem;
    w_quo_d   = r_quo;
    w_mag_b_d = r_mag_b;
    w_raw_a_d = r_raw_a;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_sa_d    = r_sa;
    w_sb_d    = r_sb;
    w_zero_d  = r_zero;
    w_busy_d  = r_busy;
    w_valid_d = 1'b0;

    case (r_state)
      StIdle: begin
        if (!bus.cancel && bus.start) begin
          w_state_d = StRun;
          w_busy_d  = 1'b1;
          w_count_d = '0;
          w_rem_d   = '0;
          w_sa_d    = w_sa_in;
          w_sb_d    = w_sb_in;
          w_quo_d   = w_sa_in ? -bus.a : bus.a;
          w_mag_b_d = w_sb_in ? -bus.b : bus.b;
          w_raw_a_d = bus.a;
          w_zero_d  = (bus.b == '0);
        end
      end
      StRun: begin
        if (bus.cancel) begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
        end else begin
          w_rem_d   = w_rem_nx;
          w_quo_d   = w_quo_nx;
          w_count_d = r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            w_state_d = StDone;
            w_busy_d  = 1'b0;
            w_valid_d = 1'b1;
            // Remainder follows the dividend's sign; divide by zero returns raw a and all ones.
            if (r_zero) begin
              w_hi_d = r_raw_a;
              w_lo_d = '1;
            end else begin
              w_hi_d = r_sa ? -w_rem_nx : w_rem_nx;
              w_lo_d = (r_sa ^ r_sb) ? -w_quo_nx : w_quo_nx;
            end
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_count <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_mag_b <= '0;
      r_raw_a <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_count <= w_count_d;
      r_rem   <= w_rem_d;
      r_quo   <= w_quo_d;
      r_mag_b <= w_mag_b_d;
      r_raw_a <= w_raw_a_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_sa    <= w_sa_d;
      r_sb    <= w_sb_d;
      r_zero  <= w_zero_d;
      r_busy  <= w_busy_d;
      r_valid <= w_valid_d;
    end
  end

  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.hi    = r_hi;
  assign bus.lo    = r_lo;
endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {hi,lo} queued at start, checked on each valid pulse.
module tb_div_unit;
  localparam int unsigned W = 32;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] mon_exp;
  logic [63:0] last_res;

  div_unit_if #(.WIDTH(W)) bus();

  div_unit #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  always @(negedge clk) begin
    if (bus.valid) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_valid", {63'd0, bus.valid}, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check_eq("hi", {32'd0, bus.hi}, {32'd0, mon_exp[63:32]});
        check_eq("lo", {32'd0, bus.lo}, {32'd0, mon_exp[31:0]});
      end
    end
  end

  // Called at a negedge (cycle N); returns at the negedge of cycle N+34.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic disturb);
    int n;
    sb_q.push_back(exp);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.a          = a;
    bus.b          = b;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (disturb && n == 2) begin
        bus.start      = 1'b1;
        bus.signed_div = ~sgn;
        bus.a          = 32'hdead_beef;
        bus.b          = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_eq("busy_cycles", 64'(n), 64'd32);
    check_eq("valid_at_n33", {63'd0, bus.valid}, 64'd1);
    @(negedge clk);
    check_eq("valid_n34", {63'd0, bus.valid}, 64'd0);
    check_eq("hold_hilo", {bus.hi, bus.lo}, exp);
    last_res = exp;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.cancel     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("rst_valid", {63'd0, bus.valid}, 64'd0);
    check_eq("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    run_div(1'b1, 32'hffff_fff9, 32'd2, {32'hffff_ffff, 32'hffff_fffd}, 1'b0);
    run_div(1'b1, 32'd7, 32'hffff_fffe, {32'd1, 32'hffff_fffd}, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hffff_ffff, {32'd0, 32'h8000_0000}, 1'b0);
    run_div(1'b0, 32'h8000_0000, 32'hffff_ffff, {32'h8000_0000, 32'd0}, 1'b0);
    run_div(1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hffff_ffff}, 1'b0);
    run_div(1'b1, 32'h8000_0005, 32'd0, {32'h8000_0005, 32'hffff_ffff}, 1'b0);
    run_div(1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 1'b1);

    // Cancel mid-run at N+10, then restart at N+12.
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.a = 32'd555;
    bus.b = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check_eq("cancel_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("cancel_hilo", {bus.hi, bus.lo}, last_res);
    @(negedge clk);
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

    // Cancel on the completing edge suppresses valid.
    bus.start = 1'b1;
    bus.a = 32'd900;
    bus.b = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (31) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check_eq("cancel_last_valid", {63'd0, bus.valid}, 64'd0);
    check_eq("cancel_last_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("cancel_last_hilo", {bus.hi, bus.lo}, last_res);

    // Start and cancel together in IDLE: nothing starts.
    bus.start = 1'b1;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    check_eq("start_cancel_busy", {63'd0, bus.busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Reset mid-operation.
    bus.start = 1'b1;
    bus.a = 32'd77;
    bus.b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check_eq("midrst_valid", {63'd0, bus.valid}, 64'd0);
    check_eq("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    run_div(1'b1, 32'hffff_ff9c, 32'd7, model(1'b1, 32'hffff_ff9c, 32'd7), 1'b0);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      rs = 1'($urandom_range(0, 1));
      run_div(rs, ra, rb, model(rs, ra, rb), 1'b0);
    end

    repeat (5) @(negedge clk);
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
